// File: rtl/fifo_mc_merge_pkg.sv
// fifo_mc_pkg: shared types and helpers for the multi-channel merge FIFO.
// Handshake states, mode constants and channel-id width.
package fifo_mc_pkg;

  localparam bit PULSE  = 1'b0;
  localparam bit STREAM = 1'b1;

  typedef enum logic {
    HS_IDLE,
    HS_ACKED
  } hs_state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_mc_merge_if.sv
// fifo_mc_merge_if: push channels, status and merged pop port.
// master = producer/consumer side, slave = the FIFO.
interface fifo_mc_merge_if #(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
) ();
  import fifo_mc_pkg::*;

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0]            push_req;
  logic [NUM_CH*DATA_WIDTH-1:0] push_data;
  logic [NUM_CH-1:0]            push_ack;
  logic [NUM_CH-1:0]            push_ack_pulse;
  logic [NUM_CH-1:0]            flush;
  logic [NUM_CH-1:0]            ch_full;
  logic [NUM_CH-1:0]            ch_empty;
  logic [NUM_CH-1:0]            ch_afull;
  logic [NUM_CH*CNT_W-1:0]      ch_count;
  logic                         pop_req;
  logic                         pop_ack;
  logic                         pop_ack_pulse;
  logic [DATA_WIDTH-1:0]        pop_data;
  logic [CH_W-1:0]              pop_ch;
  logic                         pop_valid;

  modport master (
    output push_req, push_data, flush, pop_req,
    input  push_ack, push_ack_pulse,
    input  ch_full, ch_empty, ch_afull, ch_count,
    input  pop_ack, pop_ack_pulse,
    input  pop_data, pop_ch, pop_valid
  );

  modport slave (
    input  push_req, push_data, flush, pop_req,
    output push_ack, push_ack_pulse,
    output ch_full, ch_empty, ch_afull, ch_count,
    output pop_ack, pop_ack_pulse,
    output pop_data, pop_ch, pop_valid
  );

endinterface

// File: rtl/fifo_mc_merge_req_ack_ar.sv
// req_ack_ar: one req/ack handshake controller.
// Stream flavour acks combinationally; pulse flavour acks once per req.
module req_ack_ar
  import fifo_mc_pkg::*;
#(
  parameter bit STREAM_MODE = PULSE
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic en_i,
  output logic ack_o,
  output logic ack_pulse_o
);

  hs_state_e state_q, state_d;

  // Handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HS_IDLE;
    else       state_q <= state_d;
  end

  // Transfer when idle and enabled; hold ack until req drops.
  always_comb begin
    state_d     = state_q;
    ack_o       = 1'b0;
    ack_pulse_o = 1'b0;
    if (STREAM_MODE) begin
      state_d     = HS_IDLE;
      ack_o       = req_i & en_i;
      ack_pulse_o = req_i & en_i;
    end else begin
      case (state_q)
        HS_IDLE: begin
          if (req_i && en_i) begin
            ack_pulse_o = 1'b1;
            state_d     = HS_ACKED;
          end
        end
        HS_ACKED: begin
          ack_o = 1'b1;
          if (!req_i) state_d = HS_IDLE;
        end
        default: state_d = HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_mc_merge.sv
// fifo_mc_merge: NUM_CH push queues merged onto one round-robin pop port.
// Pop data and source channel are registered; flush clears a channel.
module fifo_mc_merge
  import fifo_mc_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int DEPTH            = 8,
  parameter int DATA_WIDTH       = 32,
  parameter bit PUSH_STREAM_MODE = 1'b0,
  parameter bit POP_STREAM_MODE  = 1'b0,
  parameter int AFULL_LEVEL      = 6
) (
  input logic            clk,
  input logic            reset,
  fifo_mc_merge_if.slave bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t            mem_q  [NUM_CH][DEPTH];
  logic [PTR_W-1:0] wptr_q [NUM_CH];
  logic [PTR_W-1:0] rptr_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q  [NUM_CH];

  logic [CH_W-1:0]   rr_q, rr_d, pick;
  logic [NUM_CH-1:0] full, empty, push_en;
  logic [NUM_CH-1:0] push_fire, elig, pop_dec;
  logic              pop_en, pop_fire, pop_valid_q;
  word_t             pop_data_q;
  logic [CH_W-1:0]   pop_ch_q;
  int                idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign full[c]    = (cnt_q[c] == CNT_W'(DEPTH));
    assign empty[c]   = (cnt_q[c] == '0);
    assign push_en[c] = ~full[c] & ~bus.flush[c];
    assign elig[c]    = ~empty[c] & ~bus.flush[c];
    assign pop_dec[c] = pop_fire & (pick == CH_W'(c));

    assign bus.ch_afull[c] = (cnt_q[c] >= CNT_W'(AFULL_LEVEL));
    assign bus.ch_count[c*CNT_W +: CNT_W] = cnt_q[c];

    req_ack_ar #(
      .STREAM_MODE(PUSH_STREAM_MODE)
    ) u_push_hs (
      .clk        (clk),
      .reset      (reset),
      .req_i      (bus.push_req[c]),
      .en_i       (push_en[c]),
      .ack_o      (bus.push_ack[c]),
      .ack_pulse_o(push_fire[c])
    );
  end

  assign bus.ch_full        = full;
  assign bus.ch_empty       = empty;
  assign bus.push_ack_pulse = push_fire;

  // Round-robin pick: first eligible channel at or after rr_q.
  always_comb begin
    pick   = '0;
    pop_en = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!pop_en && elig[idx[CH_W-1:0]]) begin
        pop_en = 1'b1;
        pick   = idx[CH_W-1:0];
      end
    end
    rr_d = (int'(pick) == NUM_CH - 1) ? '0 : pick + 1'b1;
  end

  req_ack_ar #(
    .STREAM_MODE(POP_STREAM_MODE)
  ) u_pop_hs (
    .clk        (clk),
    .reset      (reset),
    .req_i      (bus.pop_req),
    .en_i       (pop_en),
    .ack_o      (bus.pop_ack),
    .ack_pulse_o(pop_fire)
  );

  // Pointer and occupancy update; flush overrides both sides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.flush[c]) begin
          wptr_q[c] <= '0;
          rptr_q[c] <= '0;
          cnt_q[c]  <= '0;
        end else begin
          if (push_fire[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
          if (pop_dec[c])   rptr_q[c] <= rptr_q[c] + 1'b1;
          if (push_fire[c] && !pop_dec[c])
            cnt_q[c] <= cnt_q[c] + 1'b1;
          else if (!push_fire[c] && pop_dec[c])
            cnt_q[c] <= cnt_q[c] - 1'b1;
        end
      end
    end
  end

  // Payload storage; occupancy guards every read, so no reset needed.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_fire[c])
        mem_q[c][wptr_q[c]] <= bus.push_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Registered pop result and round-robin pointer advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_data_q  <= '0;
      pop_ch_q    <= '0;
      pop_valid_q <= 1'b0;
      rr_q        <= '0;
    end else begin
      pop_valid_q <= pop_fire;
      if (pop_fire) begin
        pop_data_q <= mem_q[pick][rptr_q[pick]];
        pop_ch_q   <= pick;
        rr_q       <= rr_d;
      end
    end
  end

  assign bus.pop_ack_pulse = pop_fire;
  assign bus.pop_data      = pop_data_q;
  assign bus.pop_ch        = pop_ch_q;
  assign bus.pop_valid     = pop_valid_q;

endmodule

// File: tb/tb_fifo_mc_merge.sv
// tb_fifo_mc_merge: directed bench for the multi-channel merge FIFO.
// One pulse-mode and one stream-mode instance, per-channel scoreboard.
module tb_fifo_mc_merge;

  localparam int NC = 4;
  localparam int DP = 8;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   ord [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};

  logic [DW-1:0] sb [NC][$];

  fifo_mc_merge_if #(.NUM_CH(NC), .DEPTH(DP), .DATA_WIDTH(DW)) pif ();
  fifo_mc_merge_if #(.NUM_CH(NC), .DEPTH(DP), .DATA_WIDTH(DW)) sif ();

  fifo_mc_merge #(
    .NUM_CH(NC), .DEPTH(DP), .DATA_WIDTH(DW),
    .PUSH_STREAM_MODE(1'b0), .POP_STREAM_MODE(1'b0),
    .AFULL_LEVEL(6)
  ) u_pulse (
    .clk  (clk),
    .reset(reset),
    .bus  (pif.slave)
  );

  fifo_mc_merge #(
    .NUM_CH(NC), .DEPTH(DP), .DATA_WIDTH(DW),
    .PUSH_STREAM_MODE(1'b1), .POP_STREAM_MODE(1'b1),
    .AFULL_LEVEL(6)
  ) u_strm (
    .clk  (clk),
    .reset(reset),
    .bus  (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] pcnt(input int c);
    return pif.ch_count[c*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] scnt(input int c);
    return sif.ch_count[c*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] sb_pop(input int c);
    if (sb[c].size() == 0) return 32'hDEAD_BEEF;
    return sb[c].pop_front();
  endfunction

  task automatic push_pulse(input int c, input logic [DW-1:0] d);
    step();
    pif.push_req[c] = 1'b1;
    pif.push_data[c*DW +: DW] = d;
    #3;
    chk("push_pulse", pif.push_ack_pulse[c], 1);
    sb[c].push_back(d);
    step();
    pif.push_req[c] = 1'b0;
    #3;
    chk("push_ack_held", pif.push_ack[c], 1);
  endtask

  task automatic pop_pulse(input int exp_ch);
    step();
    pif.pop_req = 1'b1;
    #3;
    chk("pop_pulse", pif.pop_ack_pulse, 1);
    chk("pop_valid_idle", pif.pop_valid, 0);
    step();
    pif.pop_req = 1'b0;
    #3;
    chk("pop_valid", pif.pop_valid, 1);
    chk("pop_ch", pif.pop_ch, exp_ch);
    chk("pop_data", pif.pop_data, sb_pop(exp_ch));
  endtask

  initial begin
    pif.push_req = '0; pif.push_data = '0;
    pif.flush = '0;    pif.pop_req = 1'b0;
    sif.push_req = '0; sif.push_data = '0;
    sif.flush = '0;    sif.pop_req = 1'b0;

    // reset state
    repeat (2) step();
    #3;
    chk("rst_empty", pif.ch_empty, 4'hF);
    chk("rst_count", pif.ch_count, 0);
    chk("rst_valid", pif.pop_valid, 0);
    chk("rst_data", pif.pop_data, 0);
    chk("rst_ack", pif.push_ack, 0);
    chk("rst_s_empty", sif.ch_empty, 4'hF);
    step();
    reset = 1'b0;

    // fill ch2 with eight pulse pushes
    for (int i = 0; i < 8; i++) begin
      push_pulse(2, 32'hA0 + i);
      chk("ch2_count", pcnt(2), i + 1);
      chk("ch2_afull", pif.ch_afull[2], (i + 1) >= 6);
      chk("ch2_full", pif.ch_full[2], (i + 1) == 8);
    end

    // ninth push held off while full
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) begin
        pif.push_req[2] = 1'b1;
        pif.push_data[2*DW +: DW] = 32'hA8;
      end
      #3;
      chk("full_no_pulse", pif.push_ack_pulse[2], 0);
      chk("full_no_ack", pif.push_ack[2], 0);
    end

    // pop frees a slot; blocked push lands the following cycle
    step();
    pif.pop_req = 1'b1;
    #3;
    chk("pop_at_full", pif.pop_ack_pulse, 1);
    chk("push_wait_full", pif.push_ack_pulse[2], 0);
    step();
    pif.pop_req = 1'b0;
    #3;
    chk("pop_valid", pif.pop_valid, 1);
    chk("pop_ch", pif.pop_ch, 2);
    chk("pop_data", pif.pop_data, sb_pop(2));
    chk("ch2_count7", pcnt(2), 7);
    chk("push_after_free", pif.push_ack_pulse[2], 1);
    sb[2].push_back(32'hA8);
    step();
    pif.push_req[2] = 1'b0;
    #3;
    chk("push_ack_late", pif.push_ack[2], 1);
    chk("ch2_refull", pcnt(2), 8);

    // drain ch2 across the pointer wrap
    for (int i = 0; i < 8; i++) pop_pulse(2);
    chk("ch2_drained", pcnt(2), 0);
    chk("ch2_empty", pif.ch_empty[2], 1);

    // flush ch0 at count 5 with a concurrent push request
    for (int i = 0; i < 5; i++) push_pulse(0, 32'hC0 + i);
    for (int i = 0; i < 2; i++) push_pulse(1, 32'hD0 + i);
    chk("ch0_count5", pcnt(0), 5);
    step();
    pif.flush[0] = 1'b1;
    pif.push_req[0] = 1'b1;
    pif.push_data[0 +: DW] = 32'hCF;
    #3;
    chk("flush_no_pulse", pif.push_ack_pulse[0], 0);
    step();
    pif.flush[0] = 1'b0;
    pif.push_req[0] = 1'b0;
    #3;
    chk("flush_count", pcnt(0), 0);
    chk("flush_empty", pif.ch_empty[0], 1);
    chk("flush_other", pcnt(1), 2);
    sb[0].delete();
    pop_pulse(1);
    pop_pulse(1);

    // pulse req held ten cycles on ch3
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) begin
        pif.push_req[3] = 1'b1;
        pif.push_data[3*DW +: DW] = 32'hE5;
      end
      #3;
      pulses += int'(pif.push_ack_pulse[3]);
      chk("held_ack", pif.push_ack[3], k > 0);
    end
    chk("held_pulses", pulses, 1);
    sb[3].push_back(32'hE5);
    step();
    pif.push_req[3] = 1'b0;
    #3;
    chk("drop_ack_same", pif.push_ack[3], 1);
    step();
    #3;
    chk("drop_ack_next", pif.push_ack[3], 0);
    pop_pulse(3);

    // reset in the middle of push and pop handshakes
    push_pulse(0, 32'h11);
    push_pulse(0, 32'h22);
    step();
    pif.push_req[0] = 1'b1;
    pif.push_data[0 +: DW] = 32'h33;
    #3;
    chk("mid_push", pif.push_ack_pulse[0], 1);
    step();
    pif.pop_req = 1'b1;
    #3;
    chk("mid_pop", pif.pop_ack_pulse, 1);
    step();
    #3;
    chk("mid_valid", pif.pop_valid, 1);
    chk("mid_data", pif.pop_data, sb_pop(0));
    chk("mid_pop_ack", pif.pop_ack, 1);
    chk("mid_push_ack", pif.push_ack[0], 1);
    chk("mid_count", pcnt(0), 2);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_empty", pif.ch_empty, 4'hF);
    chk("arst_count", pif.ch_count, 0);
    chk("arst_valid", pif.pop_valid, 0);
    chk("arst_pop_ack", pif.pop_ack, 0);
    chk("arst_push_ack", pif.push_ack, 0);
    chk("arst_data", pif.pop_data, 0);
    pif.push_req = '0;
    pif.pop_req = 1'b0;
    for (int c = 0; c < NC; c++) sb[c].delete();
    step();
    reset = 1'b0;

    // pop with nothing eligible
    step();
    pif.pop_req = 1'b1;
    #3;
    chk("pop_none", pif.pop_ack_pulse, 0);
    step();
    pif.pop_req = 1'b0;

    // stream: three words each into ch0, ch1, ch3
    for (int k = 0; k < 3; k++) begin
      step();
      sif.push_req = 4'b1011;
      for (int c = 0; c < NC; c++) begin
        if (c != 2) begin
          sif.push_data[c*DW +: DW] = 32'h5000 + 16 * c + k;
          sb[c].push_back(32'h5000 + 16 * c + k);
        end
      end
      #3;
      chk("rr_push", sif.push_ack_pulse, 4'b1011);
    end
    step();
    sif.push_req = '0;
    #3;
    chk("rr_cnt0", scnt(0), 3);
    chk("rr_cnt3", scnt(3), 3);
    chk("rr_ack_off", sif.push_ack, 0);

    // round-robin drain
    for (int i = 0; i <= 9; i++) begin
      step();
      sif.pop_req = (i < 9);
      #3;
      if (i < 9) chk("rr_pop_pulse", sif.pop_ack_pulse, 1);
      if (i > 0) begin
        chk("rr_valid", sif.pop_valid, 1);
        chk("rr_order", sif.pop_ch, ord[i-1]);
        chk("rr_data", sif.pop_data, sb_pop(ord[i-1]));
      end
    end
    step();
    #3;
    chk("rr_valid_end", sif.pop_valid, 0);
    chk("rr_all_empty", sif.ch_empty, 4'hF);

    // simultaneous push and pop on ch1 at count 1
    step();
    sif.push_req[1] = 1'b1;
    sif.push_data[1*DW +: DW] = 32'h7000;
    sb[1].push_back(32'h7000);
    #3;
    chk("sim_first", sif.push_ack_pulse[1], 1);
    for (int k = 1; k <= 20; k++) begin
      step();
      sif.push_data[1*DW +: DW] = 32'h7000 + k;
      sif.pop_req = 1'b1;
      #3;
      chk("sim_push", sif.push_ack_pulse[1], 1);
      chk("sim_pop", sif.pop_ack_pulse, 1);
      chk("sim_count", scnt(1), 1);
      if (k > 1) begin
        chk("sim_valid", sif.pop_valid, 1);
        chk("sim_ch", sif.pop_ch, 1);
        chk("sim_data", sif.pop_data, sb_pop(1));
      end
      sb[1].push_back(32'h7000 + k);
    end
    step();
    sif.push_req = '0;
    sif.pop_req = 1'b0;
    #3;
    chk("sim_valid_last", sif.pop_valid, 1);
    chk("sim_data_last", sif.pop_data, sb_pop(1));
    chk("sim_count_end", scnt(1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
